// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
package mc_ctrl_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 6;
    localparam int unsigned ALUOP_W = 4;
    localparam int unsigned BR_W    = 2;
    localparam int unsigned CNT_W   = 32;

    localparam logic [OPC_W-1:0] HALT_OPC_DEF = 6'h3F;
    localparam logic [OPC_W-1:0] NOP_OPC_DEF  = 6'h3E;

    localparam logic [OPC_W-1:0] OPC_ALUR = 6'h00;
    localparam logic [OPC_W-1:0] OPC_LD   = 6'h20;
    localparam logic [OPC_W-1:0] OPC_ST   = 6'h21;
    localparam logic [OPC_W-1:0] OPC_MOVE = 6'h22;
    localparam logic [OPC_W-1:0] OPC_PUSH = 6'h23;
    localparam logic [OPC_W-1:0] OPC_POP  = 6'h24;
    localparam logic [OPC_W-1:0] OPC_CALL = 6'h25;
    localparam logic [OPC_W-1:0] OPC_RET  = 6'h26;
    localparam logic [OPC_W-1:0] OPC_JMP  = 6'h34;

    // Class masks: ALUI is 01_xxxx, BR is 11_00cc
    localparam logic [OPC_W-1:0] ALUI_MASK  = 6'h30;
    localparam logic [OPC_W-1:0] ALUI_MATCH = 6'h10;
    localparam logic [OPC_W-1:0] BR_MASK    = 6'h3C;
    localparam logic [OPC_W-1:0] BR_MATCH   = 6'h30;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 4'h0;

    localparam logic [BR_W-1:0] BR_NONE = 2'b00;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_ALUR = 4'd0,
        C_ALUI = 4'd1,
        C_LD   = 4'd2,
        C_ST   = 4'd3,
        C_MOVE = 4'd4,
        C_PUSH = 4'd5,
        C_POP  = 4'd6,
        C_CALL = 4'd7,
        C_RET  = 4'd8,
        C_BR   = 4'd9,
        C_JMP  = 4'd10,
        C_NOP  = 4'd11,
        C_HALT = 4'd12,
        C_ILL  = 4'd13
    } iclass_t;

    typedef struct packed {
        iclass_t              iclass;
        logic [ALUOP_W-1:0]   aluFn;
        logic [BR_W-1:0]      cc;
        logic                 usesSp;
        logic                 spDown;
        logic                 memRd;
        logic                 memWr;
        logic                 wrReg;
        logic                 memToReg;
    } dec_t;

    typedef struct packed {
        logic               PCUpdate;
        logic               regDest;
        logic               writeSP;
        logic               readSP;
        logic               updateSP;
        logic               writeReg;
        logic               aluSource;
        logic               PM4;
        logic               spmmux;
        logic               retMem;
        logic               memRead;
        logic               memWrite;
        logic               memReg;
        logic               spmux;
        logic               moveReg;
        logic               jump;
        logic               retPC;
        logic               haltPC;
        logic [BR_W-1:0]    branch;
        logic [ALUOP_W-1:0] aluOp;
        logic               halted;
        logic               retire;
        logic               illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode classifier: instruction fields -> class and per-class strobe hints.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
#(
    parameter logic [OPC_W-1:0] HALT_OPC = HALT_OPC_DEF,
    parameter logic [OPC_W-1:0] NOP_OPC  = NOP_OPC_DEF
) (
    input  logic [OPC_W-1:0]   opc,
    input  logic [ALUOP_W-1:0] fn,
    output dec_t               dec
);

    always_comb begin
        dec.iclass   = C_ILL;
        dec.aluFn    = ALU_ADD;
        dec.cc       = BR_NONE;
        dec.usesSp   = 1'b0;
        dec.spDown   = 1'b0;
        dec.memRd    = 1'b0;
        dec.memWr    = 1'b0;
        dec.wrReg    = 1'b0;
        dec.memToReg = 1'b0;

        // HALT/NOP are parameterised, so they take priority over the class masks
        if (opc == HALT_OPC) begin
            dec.iclass = C_HALT;
        end else if (opc == NOP_OPC) begin
            dec.iclass = C_NOP;
        end else if (opc == OPC_ALUR) begin
            dec.iclass = C_ALUR;
            dec.aluFn  = fn;
            dec.wrReg  = 1'b1;
        end else if ((opc & ALUI_MASK) == ALUI_MATCH) begin
            dec.iclass = C_ALUI;
            dec.aluFn  = opc[ALUOP_W-1:0];
            dec.wrReg  = 1'b1;
        end else if ((opc & BR_MASK) == BR_MATCH) begin
            dec.iclass = C_BR;
            dec.cc     = opc[BR_W-1:0];
        end else begin
            case (opc)
                OPC_LD: begin
                    dec.iclass   = C_LD;
                    dec.memRd    = 1'b1;
                    dec.wrReg    = 1'b1;
                    dec.memToReg = 1'b1;
                end
                OPC_ST: begin
                    dec.iclass = C_ST;
                    dec.memWr  = 1'b1;
                end
                OPC_MOVE: begin
                    dec.iclass = C_MOVE;
                    dec.wrReg  = 1'b1;
                end
                OPC_PUSH: begin
                    dec.iclass = C_PUSH;
                    dec.usesSp = 1'b1;
                    dec.spDown = 1'b1;
                    dec.memWr  = 1'b1;
                end
                OPC_POP: begin
                    dec.iclass   = C_POP;
                    dec.usesSp   = 1'b1;
                    dec.memRd    = 1'b1;
                    dec.wrReg    = 1'b1;
                    dec.memToReg = 1'b1;
                end
                OPC_CALL: begin
                    dec.iclass = C_CALL;
                    dec.usesSp = 1'b1;
                    dec.spDown = 1'b1;
                    dec.memWr  = 1'b1;
                end
                OPC_RET: begin
                    dec.iclass   = C_RET;
                    dec.usesSp   = 1'b1;
                    dec.memRd    = 1'b1;
                    dec.memToReg = 1'b1;
                end
                OPC_JMP: dec.iclass = C_JMP;
                default: dec.iclass = C_ILL;
            endcase
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the datapath strobes.
// Define PERF_CNT_EN to add the cycle_cnt/instr_cnt performance counters.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter logic [OPC_W-1:0] HALT_OPC = HALT_OPC_DEF,
    parameter logic [OPC_W-1:0] NOP_OPC  = NOP_OPC_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    output logic               PCUpdate,
    output logic               regDest,
    output logic               writeSP,
    output logic               readSP,
    output logic               updateSP,
    output logic               writeReg,
    output logic               aluSource,
    output logic               PM4,
    output logic               spmmux,
    output logic               retMem,
    output logic               memRead,
    output logic               memWrite,
    output logic               memReg,
    output logic               spmux,
    output logic               moveReg,
    output logic               jump,
    output logic               retPC,
    output logic               haltPC,
    output logic [BR_W-1:0]    branch,
    output logic [ALUOP_W-1:0] aluOp,
    output logic               halted,
    output logic               retire,
    output logic               illegal
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   instr_cnt
`endif
);

    state_t             state;
    state_t             nextState;
    logic [INSTR_W-1:0] ir;
    logic [INSTR_W-1:0] nextIr;
    ctrl_t              ctrl;
    ctrl_t              ctrlNext;
    dec_t               dec;
    logic               unusedIrBits;

    // Decoding the next IR lets the strobes be registered yet still track state/IR
    assign nextIr       = (state == S_FETCH) ? instr : ir;
    assign unusedIrBits = ^ir[25:4];

    mc_ctrl_decode #(
        .HALT_OPC (HALT_OPC),
        .NOP_OPC  (NOP_OPC)
    ) u_decode (
        .opc (nextIr[31:26]),
        .fn  (nextIr[ALUOP_W-1:0]),
        .dec (dec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            ir    <= '0;
            ctrl  <= '0;
        end else begin
            state <= nextState;
            ir    <= nextIr;
            ctrl  <= ctrlNext;
        end
    end

    always_comb begin
        nextState = state;
        ctrlNext  = '0;

        case (state)
            S_FETCH:  nextState = S_DECODE;
            S_DECODE: begin
                if (dec.iclass == C_HALT)
                    nextState = S_HALT;
                else if (dec.iclass == C_NOP || dec.iclass == C_ILL)
                    nextState = S_WB;
                else
                    nextState = S_EXEC;
            end
            S_EXEC:   nextState = (dec.iclass == C_MOVE) ? S_WB : S_MEM;
            S_MEM:    nextState = S_WB;
            S_WB:     nextState = S_FETCH;
            S_HALT:   nextState = S_HALT;
            default:  nextState = S_FETCH;
        endcase

        // ALU steering and branch select hold from EXEC through WB
        if (nextState inside {S_EXEC, S_MEM, S_WB}) begin
            ctrlNext.aluOp     = dec.aluFn;
            ctrlNext.regDest   = (dec.iclass == C_ALUR);
            ctrlNext.aluSource = (dec.iclass == C_ALUI);
            ctrlNext.branch    = dec.cc;
        end

        case (nextState)
            S_DECODE: begin
                ctrlNext.readSP  = dec.usesSp;
                ctrlNext.illegal = (dec.iclass == C_ILL);
            end
            S_EXEC: begin
                ctrlNext.spmux = dec.usesSp;
                ctrlNext.PM4   = dec.spDown;
            end
            S_MEM: begin
                ctrlNext.memRead  = dec.memRd;
                ctrlNext.memWrite = dec.memWr;
                ctrlNext.retMem   = (dec.iclass == C_CALL);
                ctrlNext.updateSP = (dec.iclass == C_CALL);
                ctrlNext.writeSP  = (dec.iclass == C_PUSH) || (dec.iclass == C_POP)
                                    || (dec.iclass == C_CALL);
            end
            S_WB: begin
                ctrlNext.PCUpdate = 1'b1;
                ctrlNext.retire   = 1'b1;
                ctrlNext.writeReg = dec.wrReg;
                ctrlNext.memReg   = dec.memToReg;
                ctrlNext.moveReg  = (dec.iclass == C_MOVE);
                ctrlNext.retPC    = (dec.iclass == C_RET);
                ctrlNext.writeSP  = (dec.iclass == C_RET);
                ctrlNext.jump     = (dec.iclass == C_JMP) || (dec.iclass == C_CALL);
            end
            S_HALT: begin
                ctrlNext.haltPC   = 1'b1;
                ctrlNext.halted   = 1'b1;
                ctrlNext.PCUpdate = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCUpdate  = ctrl.PCUpdate;
    assign regDest   = ctrl.regDest;
    assign writeSP   = ctrl.writeSP;
    assign readSP    = ctrl.readSP;
    assign updateSP  = ctrl.updateSP;
    assign writeReg  = ctrl.writeReg;
    assign aluSource = ctrl.aluSource;
    assign PM4       = ctrl.PM4;
    assign spmmux    = ctrl.spmmux;
    assign retMem    = ctrl.retMem;
    assign memRead   = ctrl.memRead;
    assign memWrite  = ctrl.memWrite;
    assign memReg    = ctrl.memReg;
    assign spmux     = ctrl.spmux;
    assign moveReg   = ctrl.moveReg;
    assign jump      = ctrl.jump;
    assign retPC     = ctrl.retPC;
    assign haltPC    = ctrl.haltPC;
    assign branch    = ctrl.branch;
    assign aluOp     = ctrl.aluOp;
    assign halted    = ctrl.halted;
    assign retire    = ctrl.retire;
    assign illegal   = ctrl.illegal;

`ifdef PERF_CNT_EN
    // Cycle count freezes while parked in HALT; both counters wrap naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (state != S_HALT)
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (ctrl.retire)
                instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed-vector bench for mc_control_fsm; checks every strobe per cycle against hand tables.
module tb_mc_control_fsm;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        PCUpdate, regDest, writeSP, readSP, updateSP, writeReg, aluSource, PM4;
    logic        spmmux, retMem, memRead, memWrite, memReg, spmux, moveReg, jump, retPC, haltPC;
    logic [1:0]  branch;
    logic [3:0]  aluOp;
    logic        halted, retire, illegal;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    mc_control_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .PCUpdate  (PCUpdate),
        .regDest   (regDest),
        .writeSP   (writeSP),
        .readSP    (readSP),
        .updateSP  (updateSP),
        .writeReg  (writeReg),
        .aluSource (aluSource),
        .PM4       (PM4),
        .spmmux    (spmmux),
        .retMem    (retMem),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .memReg    (memReg),
        .spmux     (spmux),
        .moveReg   (moveReg),
        .jump      (jump),
        .retPC     (retPC),
        .haltPC    (haltPC),
        .branch    (branch),
        .aluOp     (aluOp),
        .halted    (halted),
        .retire    (retire),
        .illegal   (illegal)
`ifdef PERF_CNT_EN
        ,
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
`endif
    );

    // Strobe bit positions inside the packed observation word
    localparam logic [20:0] Z    = 21'h000000;
    localparam logic [20:0] PCU  = 21'h100000;
    localparam logic [20:0] RDST = 21'h080000;
    localparam logic [20:0] WSP  = 21'h040000;
    localparam logic [20:0] RSP  = 21'h020000;
    localparam logic [20:0] USP  = 21'h010000;
    localparam logic [20:0] WREG = 21'h008000;
    localparam logic [20:0] ASRC = 21'h004000;
    localparam logic [20:0] PM4B = 21'h002000;
    localparam logic [20:0] RMEM = 21'h000800;
    localparam logic [20:0] MRD  = 21'h000400;
    localparam logic [20:0] MWR  = 21'h000200;
    localparam logic [20:0] MREG = 21'h000100;
    localparam logic [20:0] SPMX = 21'h000080;
    localparam logic [20:0] MOV  = 21'h000040;
    localparam logic [20:0] JMPB = 21'h000020;
    localparam logic [20:0] RPC  = 21'h000010;
    localparam logic [20:0] HPC  = 21'h000008;
    localparam logic [20:0] HLT  = 21'h000004;
    localparam logic [20:0] RTB  = 21'h000002;
    localparam logic [20:0] ILL  = 21'h000001;
    localparam logic [31:0] NA   = 32'h0;

    logic [31:0] obs;
    assign obs = {5'b0, PCUpdate, regDest, writeSP, readSP, updateSP, writeReg, aluSource, PM4,
                  spmmux, retMem, memRead, memWrite, memReg, spmux, moveReg, jump, retPC,
                  haltPC, halted, retire, illegal, aluOp, branch};

    int checks      = 0;
    int fails       = 0;
    int expCycles   = 0;
    int expRetired  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ex(input logic [20:0] s, input logic [3:0] a,
                                       input logic [1:0] b);
        return {5'b0, s, a, b};
    endfunction

    task automatic step(input string tag, input logic [31:0] exp);
        @(posedge clk);
        #1;
        checkVal(tag, obs, exp);
    endtask

    // Called from FETCH; samples cycles 2..lat, then the following FETCH
    task automatic runInstr(input string tag, input logic [31:0] word, input int lat,
                            input logic [31:0] e2, input logic [31:0] e3,
                            input logic [31:0] e4, input logic [31:0] eWb);
        instr = word;
        step({tag, "/c2"}, e2);
        if (lat >= 4) step({tag, "/c3"}, e3);
        if (lat == 5) step({tag, "/c4"}, e4);
        step({tag, "/wb"}, eWb);
        step({tag, "/fetch"}, NA);
        expCycles  += lat;
        expRetired += 1;
    endtask

    initial begin
        reset = 1'b1;
        instr = 32'h00221802;
        repeat (2) @(posedge clk);
        #1;
        checkVal("rst_hold", obs, NA);
`ifdef PERF_CNT_EN
        checkVal("rst_cycle_cnt", cycle_cnt, 32'd0);
        checkVal("rst_instr_cnt", instr_cnt, 32'd0);
`endif

        // Start an ALUR, then abort it with reset while in EXEC
        @(negedge clk) reset = 1'b0;
        step("pre/decode", ex(Z, 4'h0, 2'b00));
        step("pre/exec", ex(RDST, 4'h2, 2'b00));
        #2 reset = 1'b1;
        #1 checkVal("rst_async", obs, NA);
        step("rst_edge", NA);
        @(negedge clk) reset = 1'b0;

        runInstr("alur", 32'h00221802, 5, ex(Z, 4'h0, 2'b00), ex(RDST, 4'h2, 2'b00),
                 ex(RDST, 4'h2, 2'b00), ex(PCU | RDST | WREG | RTB, 4'h2, 2'b00));
        runInstr("nop", 32'hF8000000, 3, ex(Z, 4'h0, 2'b00), NA, NA,
                 ex(PCU | RTB, 4'h0, 2'b00));
        runInstr("push", 32'h8C000000, 5, ex(RSP, 4'h0, 2'b00), ex(SPMX | PM4B, 4'h0, 2'b00),
                 ex(MWR | WSP, 4'h0, 2'b00), ex(PCU | RTB, 4'h0, 2'b00));
        runInstr("pop", 32'h90000000, 5, ex(RSP, 4'h0, 2'b00), ex(SPMX, 4'h0, 2'b00),
                 ex(MRD | WSP, 4'h0, 2'b00), ex(PCU | RTB | WREG | MREG, 4'h0, 2'b00));
        runInstr("call", 32'h94000000, 5, ex(RSP, 4'h0, 2'b00), ex(SPMX | PM4B, 4'h0, 2'b00),
                 ex(MWR | RMEM | USP | WSP, 4'h0, 2'b00), ex(PCU | RTB | JMPB, 4'h0, 2'b00));
        runInstr("ret", 32'h98000000, 5, ex(RSP, 4'h0, 2'b00), ex(SPMX, 4'h0, 2'b00),
                 ex(MRD, 4'h0, 2'b00), ex(PCU | RTB | RPC | MREG | WSP, 4'h0, 2'b00));
        runInstr("alui", 32'h7C000000, 5, ex(Z, 4'h0, 2'b00), ex(ASRC, 4'hF, 2'b00),
                 ex(ASRC, 4'hF, 2'b00), ex(PCU | RTB | WREG | ASRC, 4'hF, 2'b00));
        runInstr("ld", 32'h80000000, 5, ex(Z, 4'h0, 2'b00), ex(Z, 4'h0, 2'b00),
                 ex(MRD, 4'h0, 2'b00), ex(PCU | RTB | WREG | MREG, 4'h0, 2'b00));
        runInstr("st", 32'h84000000, 5, ex(Z, 4'h0, 2'b00), ex(Z, 4'h0, 2'b00),
                 ex(MWR, 4'h0, 2'b00), ex(PCU | RTB, 4'h0, 2'b00));
        runInstr("move", 32'h88000000, 4, ex(Z, 4'h0, 2'b00), ex(Z, 4'h0, 2'b00), NA,
                 ex(PCU | RTB | WREG | MOV, 4'h0, 2'b00));
        runInstr("br", 32'hC8000000, 5, ex(Z, 4'h0, 2'b00), ex(Z, 4'h0, 2'b10),
                 ex(Z, 4'h0, 2'b10), ex(PCU | RTB, 4'h0, 2'b10));
        runInstr("jmp", 32'hD0000000, 5, ex(Z, 4'h0, 2'b00), ex(Z, 4'h0, 2'b00),
                 ex(Z, 4'h0, 2'b00), ex(PCU | RTB | JMPB, 4'h0, 2'b00));
        runInstr("ill27", 32'h9C000000, 3, ex(ILL, 4'h0, 2'b00), NA, NA,
                 ex(PCU | RTB, 4'h0, 2'b00));
        runInstr("ill38", 32'hE0000000, 3, ex(ILL, 4'h0, 2'b00), NA, NA,
                 ex(PCU | RTB, 4'h0, 2'b00));

        // HALT parks for good; two counted cycles (FETCH, DECODE) precede it
        instr = 32'hFC000000;
        step("halt/decode", ex(Z, 4'h0, 2'b00));
        step("halt/enter", ex(PCU | HPC | HLT, 4'h0, 2'b00));
`ifdef PERF_CNT_EN
        checkVal("halt_cycle_cnt_entry", cycle_cnt, 32'(expCycles + 2));
`endif
        instr = 32'h00221802;
        for (int i = 0; i < 99; i++) begin
            step("halt/park", ex(PCU | HPC | HLT, 4'h0, 2'b00));
        end
`ifdef PERF_CNT_EN
        checkVal("halt_cycle_cnt_frozen", cycle_cnt, 32'(expCycles + 2));
        checkVal("halt_instr_cnt", instr_cnt, 32'(expRetired));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
